// File: rtl/waterfall_ctrl.sv
// waterfall_ctrl: LED waterfall sequencer with prescaler, start/stop/pause and four patterns; define WATERFALL_ACTIVE_LOW_EN for active-low LEDs
module waterfall_ctrl #(
  parameter int LED_W    = 8,
  parameter int DIV_W    = 26,
  parameter int DIV_SLOW = 49_999_999,
  parameter int DIV_MED  = 24_999_999,
  parameter int DIV_FAST = 4_999_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             step_tick
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_sel;
  logic [LED_W-1:0] pat_q, pat_d, pat_init, pat_step;
  logic [1:0] mode_q, mode_d;
  logic dir_q, dir_d, dir_step, tick_q, tick_d, busy_q, wrap;
  assign div_sel  = speed == 2'b00 ? DIV_W'(DIV_SLOW) : speed == 2'b01 ? DIV_W'(DIV_MED) : DIV_W'(DIV_FAST);
  assign pat_init = mode == 2'b01 ? {1'b1, {(LED_W-1){1'b0}}} : LED_W'(1);
  assign wrap     = cnt_q == div_q;
  // next pattern and ping-pong direction for the latched mode (dir 1 = moving right)
  always_comb begin
    pat_step = pat_q;
    dir_step = dir_q;
    case (mode_q)
      2'b00: pat_step = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
      2'b01: pat_step = {pat_q[0], pat_q[LED_W-1:1]};
      2'b10: begin
        pat_step = dir_q ? pat_q >> 1 : pat_q << 1;
        dir_step = dir_q ? !pat_step[0] : pat_step[LED_W-1];
      end
      default: pat_step = &pat_q ? '0 : {pat_q[LED_W-2:0], 1'b1};
    endcase
  end
  // control: stop beats start beats pause; a paused cycle with pause low counts like RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      pat_d   = '0;
    end else if (start) begin
      state_d = RUN;
      mode_d  = mode;
      div_d   = div_sel;
      cnt_d   = '0;
      dir_d   = 1'b0;
      pat_d   = pat_init;
    end else if (state_q != IDLE) begin
      state_d = pause ? PAUSE : RUN;
      if (!pause) begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        if (wrap) begin
          pat_d  = pat_step;
          dir_d  = dir_step;
          div_d  = div_sel;
          tick_d = 1'b1;
        end
      end
    end
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      div_q   <= DIV_W'(DIV_SLOW);
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      busy_q  <= state_d != IDLE;
    end
  end
`ifdef WATERFALL_ACTIVE_LOW_EN
  assign led = ~pat_q;
`else
  assign led = pat_q;
`endif
  assign busy      = busy_q;
  assign step_tick = tick_q;
endmodule

// File: tb/tb_waterfall_ctrl.sv
// tb_waterfall_ctrl: directed self-checking bench for waterfall_ctrl (LED_W=4, divs 7/3/1)
module tb_waterfall_ctrl;
  logic clk = 1'b0, rst, start, stop, pause;
  logic [1:0] mode, speed;
  logic [3:0] led;
  logic busy, step_tick;
  int total = 0, fails = 0;
  waterfall_ctrl #(.LED_W(4), .DIV_W(4), .DIV_SLOW(7), .DIV_MED(3), .DIV_FAST(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .speed(speed), .led(led), .busy(busy), .step_tick(step_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_led(input string tag, input logic [3:0] p);
`ifdef WATERFALL_ACTIVE_LOW_EN
    chk(tag, 32'(led), 32'(~p));
`else
    chk(tag, 32'(led), 32'(p));
`endif
  endtask
  task automatic do_start(input logic [1:0] m, input logic [1:0] s, input logic [3:0] p, input string tag);
    mode = m;
    speed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_led({tag, "_init"}, p);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_notick"}, 32'(step_tick), 0);
  endtask
  task automatic tick_after(input int n, input logic [3:0] p, input string tag);
    repeat (n - 1) @(negedge clk);
    chk({tag, "_quiet"}, 32'(step_tick), 0);
    @(negedge clk);
    chk({tag, "_tick"}, 32'(step_tick), 1);
    chk_led({tag, "_led"}, p);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'b00; speed = 2'b00;
    repeat (2) @(negedge clk);
    chk_led("rst_led", 4'b0000);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(step_tick), 0);
    rst = 1'b0;
    do_start(2'b00, 2'b01, 4'b0001, "rotl");
    tick_after(4, 4'b0010, "rotl1");
    tick_after(4, 4'b0100, "rotl2");
    tick_after(4, 4'b1000, "rotl3");
    tick_after(4, 4'b0001, "rotl4");
    chk("rotl_busy", 32'(busy), 1);
    do_start(2'b01, 2'b10, 4'b1000, "rotr");
    tick_after(2, 4'b0100, "rotr1");
    tick_after(2, 4'b0010, "rotr2");
    tick_after(2, 4'b0001, "rotr3");
    tick_after(2, 4'b1000, "rotr4");
    do_start(2'b10, 2'b10, 4'b0001, "pp");
    tick_after(2, 4'b0010, "pp1");
    tick_after(2, 4'b0100, "pp2");
    tick_after(2, 4'b1000, "pp3");
    tick_after(2, 4'b0100, "pp4");
    tick_after(2, 4'b0010, "pp5");
    tick_after(2, 4'b0001, "pp6");
    tick_after(2, 4'b0010, "pp7");
    tick_after(2, 4'b0100, "pp8");
    do_start(2'b00, 2'b00, 4'b0001, "pz");
    repeat (3) @(negedge clk);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("pz_hold_tick", 32'(step_tick), 0);
      chk_led("pz_hold_led", 4'b0001);
      chk("pz_hold_busy", 32'(busy), 1);
    end
    pause = 1'b0;
    tick_after(5, 4'b0010, "pz_resume");
    tick_after(8, 4'b0100, "pz_next");
    @(negedge clk);
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    chk_led("ss_led", 4'b0000);
    chk("ss_busy", 32'(busy), 0);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
    chk_led("idle_pause_led", 4'b0000);
    chk("idle_pause_busy", 32'(busy), 0);
    chk("idle_pause_tick", 32'(step_tick), 0);
    do_start(2'b00, 2'b01, 4'b0001, "restart");
    do_start(2'b00, 2'b00, 4'b0001, "spd");
    repeat (3) @(negedge clk);
    speed = 2'b10;
    mode = 2'b01;
    tick_after(5, 4'b0010, "spd_cur");
    tick_after(2, 4'b0100, "spd_new1");
    tick_after(2, 4'b1000, "spd_new2");
    do_start(2'b11, 2'b10, 4'b0001, "fill");
    tick_after(2, 4'b0011, "fill1");
    tick_after(2, 4'b0111, "fill2");
    tick_after(2, 4'b1111, "fill3");
    tick_after(2, 4'b0000, "fill4");
    tick_after(2, 4'b0001, "fill5");
    chk("fill_busy", 32'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_led("stop_led", 4'b0000);
    chk("stop_busy", 32'(busy), 0);
    do_start(2'b00, 2'b10, 4'b0001, "pre_rst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_led("midrst_led", 4'b0000);
    chk("midrst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("midrst_tick", 32'(step_tick), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
